uart_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the single UART transmit stream between `N_SOURCES` packet producers: the ReceiveStream acknowledgement/timeout path, register-read replies and status reports. It sits between those producers and the UART packetiser. It grants one source per packet, forwards that source's beats through a registered output stage, and releases the grant on EoP. It also checks beat count against the header `Length` field and guards against stalled sources.

---
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin arbiter sharing one UART transmit stream between packet sources
package uart_tx_arbiter_pkg;
  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       SoP;
    logic       EoP;
    logic       Valid;
  } UART_PACKET;
endpackage

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_SOURCES = 3,
  parameter int TIMEOUT   = 65535
) (
  input  logic                         ipClk,
  input  logic                         ipReset,
  input  UART_PACKET                   ipStream [N_SOURCES],
  output logic [N_SOURCES-1:0]         opReady,
  output UART_PACKET                   opTxStream,
  input  logic                         ipTxReady,
  output logic [$clog2(N_SOURCES)-1:0] opGrant,
  output logic                         opLengthError,
  output logic                         opTimeout,
  output logic [15:0]                  opDropCount
);
  localparam int GW = $clog2(N_SOURCES);
  typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_t;
  state_t state, next_state;
  UART_PACKET cur, load;
  logic [N_SOURCES-1:0] orphan, ready;
  logic [GW-1:0] win;
  logic found, sop_any, pass_acc, flush_acc, len_bad;
  logic [8:0] beat_cnt, exp_cnt;
  logic [15:0] stall_cnt, drop_next;
  logic [16:0] drop_sum;
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] g, input int k);
    return GW'((int'(g) + k) % N_SOURCES);
  endfunction
  always_comb begin
    found = 1'b0;
    win = opGrant;
    sop_any = 1'b0;
    orphan = '0;
    drop_sum = {1'b0, opDropCount};
    for (int k = 1; k <= N_SOURCES; k++)
      if (!found && ipStream[rr_idx(opGrant, k)].Valid && ipStream[rr_idx(opGrant, k)].SoP) begin
        found = 1'b1;
        win = rr_idx(opGrant, k);
      end
    for (int i = 0; i < N_SOURCES; i++) begin
      sop_any = sop_any | (ipStream[i].Valid & ipStream[i].SoP);
      orphan[i] = state == IDLE && ipStream[i].Valid && !ipStream[i].SoP;
      drop_sum = drop_sum + 17'(orphan[i]);
    end
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    cur = ipStream[opGrant];
    load = cur;
    load.Valid = 1'b1;
    pass_acc = state == PASS && cur.Valid && (!opTxStream.Valid || ipTxReady);
    flush_acc = state == FLUSH && cur.Valid && !sop_any;
    exp_cnt = cur.Length == 8'd0 ? 9'd256 : {1'b0, cur.Length};
    len_bad = beat_cnt + 9'd1 != exp_cnt;
    ready = orphan;
    if (state == PASS) ready[opGrant] = !opTxStream.Valid || ipTxReady;
    if (state == FLUSH) ready[opGrant] = !sop_any;
    next_state = state == IDLE ? (found ? PASS : IDLE)
               : state == PASS ? (pass_acc && cur.EoP ? IDLE
                                 : !pass_acc && stall_cnt == 16'(TIMEOUT - 1) ? FLUSH : PASS)
               : (sop_any || (flush_acc && cur.EoP)) ? IDLE : FLUSH;
  end
  assign opReady = ipReset ? ready : '0;
  always_ff @(posedge ipClk or negedge ipReset)
    if (!ipReset) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge ipClk or negedge ipReset)
    if (!ipReset) begin
      opTxStream <= '0;
      opGrant <= GW'(N_SOURCES - 1);
      opLengthError <= 1'b0;
      opTimeout <= 1'b0;
      opDropCount <= '0;
      beat_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      opLengthError <= pass_acc && cur.EoP && len_bad;
      opTimeout <= state == PASS && next_state == FLUSH;
      opDropCount <= drop_next;
      if (pass_acc) opTxStream <= load;
      else if (ipTxReady) opTxStream.Valid <= 1'b0;
      if (state == IDLE && found) begin
        opGrant <= win;
        beat_cnt <= '0;
        stall_cnt <= '0;
      end else if (pass_acc) begin
        beat_cnt <= beat_cnt + 9'd1;
        stall_cnt <= '0;
      end else if (state == PASS) stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the packet arbiter with directed packets
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;
  localparam int N = 3;
  logic ipClk = 1'b0;
  logic ipReset = 1'b0;
  logic ipTxReady = 1'b1;
  UART_PACKET ipStream [N];
  logic [N-1:0] opReady;
  UART_PACKET opTxStream;
  logic [1:0] opGrant;
  logic opLengthError, opTimeout;
  logic [15:0] opDropCount;
  typedef struct {
    UART_PACKET p;
    bit lerr;
    bit gap;
  } sb_t;
  sb_t sbq[$];
  int total = 0, bad = 0, cyc = 0, le_cnt = 0, to_cnt = 0, to_cyc = 0, last_eop = 0, first_out = 0;
  bit bp = 1'b0;
  uart_tx_arbiter #(.N_SOURCES(N), .TIMEOUT(16)) dut (
    .ipClk(ipClk),
    .ipReset(ipReset),
    .ipStream(ipStream),
    .opReady(opReady),
    .opTxStream(opTxStream),
    .ipTxReady(ipTxReady),
    .opGrant(opGrant),
    .opLengthError(opLengthError),
    .opTimeout(opTimeout),
    .opDropCount(opDropCount)
  );
  always #5 ipClk = ~ipClk;
  always @(posedge ipClk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic UART_PACKET mk(input int s, len, i, n, base);
    UART_PACKET p;
    p.Source = 8'(s);
    p.Destination = 8'h5A;
    p.Length = 8'(len);
    p.Data = 8'(base + i);
    p.SoP = i == 0;
    p.EoP = i == n - 1;
    p.Valid = 1'b1;
    return p;
  endfunction
  task automatic push_pkt(input int s, len, n, base, input bit lerr, gap);
    for (int i = 0; i < n; i++) sbq.push_back('{mk(s, len, i, n, base), lerr && i == n - 1, gap && i == 0});
  endtask
  task automatic put_beat(input int s, input UART_PACKET p);
    bit hs = 1'b0;
    int n = 0;
    ipStream[s] = p;
    while (!hs && n < 1000) begin
      #4 hs = opReady[s];
      @(negedge ipClk);
      n++;
    end
    if (!hs) chk("handshake", 64'(hs), 64'd1);
  endtask
  task automatic send_pkt(input int s, len, n, base);
    for (int i = 0; i < n; i++) put_beat(s, mk(s, len, i, n, base));
    ipStream[s] = '0;
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge ipClk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge ipClk);
  endtask
  initial forever begin
    @(negedge ipClk);
    ipTxReady = bp ? !ipTxReady : 1'b1;
  end
  initial begin
    sb_t e;
    forever begin
      @(negedge ipClk);
      #4;
      if (opTimeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (opLengthError) le_cnt++;
      if (opTxStream.Valid && ipTxReady) begin
        if (sbq.size() == 0) chk("unexpected_beat", 64'(opTxStream), 64'd0);
        else begin
          e = sbq.pop_front();
          chk("beat", 64'(opTxStream), 64'(e.p));
          chk("grant", 64'(opGrant), 64'(e.p.Source));
          if (e.gap) chk("rr_gap", 64'(cyc - last_eop), 64'd2);
          if (e.p.EoP) begin
            chk("len_err", 64'(opLengthError), 64'(e.lerr));
            last_eop = cyc;
          end
          if (e.p.SoP) first_out = cyc;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int t, le0, to0;
    for (int i = 0; i < N; i++) ipStream[i] = '0;
    repeat (2) @(negedge ipClk);
    chk("rst_tx", 64'(opTxStream), 64'd0);
    chk("rst_ready", 64'(opReady), 64'd0);
    chk("rst_grant", 64'(opGrant), 64'd2);
    chk("rst_lerr", 64'(opLengthError), 64'd0);
    chk("rst_to", 64'(opTimeout), 64'd0);
    chk("rst_drop", 64'(opDropCount), 64'd0);
    ipReset = 1'b1;
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < N; s++) push_pkt(s, 2, 2, 16 * s + 2 * p, 1'b0, !(p == 0 && s == 0));
    fork
      begin for (int p = 0; p < 4; p++) send_pkt(0, 2, 2, 2 * p); end
      begin for (int p = 0; p < 4; p++) send_pkt(1, 2, 2, 16 + 2 * p); end
      begin for (int p = 0; p < 4; p++) send_pkt(2, 2, 2, 32 + 2 * p); end
    join
    drain();
    chk("rr_drop", 64'(opDropCount), 64'd0);
    t = cyc;
    le0 = le_cnt;
    to0 = to_cnt;
    push_pkt(0, 4, 4, 0, 1'b0, 1'b0);
    send_pkt(0, 4, 4, 0);
    drain();
    chk("latency", 64'(first_out - t), 64'd2);
    chk("grant0", 64'(opGrant), 64'd0);
    chk("single_lerr", 64'(le_cnt), 64'(le0));
    chk("single_to", 64'(to_cnt), 64'(to0));
    bp = 1'b1;
    push_pkt(0, 0, 256, 0, 1'b0, 1'b0);
    send_pkt(0, 0, 256, 0);
    drain();
    bp = 1'b0;
    chk("bp_lerr", 64'(le_cnt), 64'(le0));
    push_pkt(1, 5, 4, 64, 1'b1, 1'b0);
    send_pkt(1, 5, 4, 64);
    drain();
    chk("lerr_count", 64'(le_cnt), 64'(le0 + 1));
    for (int k = 0; k < 3; k++) put_beat(2, mk(2, 3, 1 + k, 10, 80));
    ipStream[2] = '0;
    repeat (2) @(negedge ipClk);
    chk("drop3", 64'(opDropCount), 64'd3);
    sbq.push_back('{mk(1, 3, 0, 3, 96), 1'b0, 1'b0});
    put_beat(1, mk(1, 3, 0, 3, 96));
    t = cyc;
    ipStream[1] = '0;
    repeat (20) @(negedge ipClk);
    put_beat(1, mk(1, 3, 1, 3, 96));
    put_beat(1, mk(1, 3, 2, 3, 96));
    ipStream[1] = '0;
    push_pkt(2, 2, 2, 112, 1'b0, 1'b0);
    send_pkt(2, 2, 2, 112);
    drain();
    chk("to_count", 64'(to_cnt), 64'(to0 + 1));
    chk("to_delay", 64'(to_cyc - t), 64'd16);
    chk("to_drop", 64'(opDropCount), 64'd3);
    chk("grant2", 64'(opGrant), 64'd2);
    for (int i = 0; i < 10; i++) sbq.push_back('{mk(0, 20, i, 20, 100), 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) put_beat(0, mk(0, 20, i, 20, 100));
    ipStream[0] = mk(0, 20, 10, 20, 100);
    @(negedge ipClk);
    ipStream[0] = mk(0, 20, 11, 20, 100);
    #1 ipReset = 1'b0;
    #1;
    chk("rst2_tx", 64'(opTxStream), 64'd0);
    chk("rst2_ready", 64'(opReady), 64'd0);
    chk("rst2_grant", 64'(opGrant), 64'd2);
    chk("rst2_drop", 64'(opDropCount), 64'd0);
    chk("rst2_flags", 64'({opLengthError, opTimeout}), 64'd0);
    chk("rst2_queue", 64'(sbq.size()), 64'd0);
    repeat (2) @(negedge ipClk);
    ipStream[0] = '0;
    @(negedge ipClk);
    ipReset = 1'b1;
    push_pkt(0, 2, 2, 200, 1'b0, 1'b0);
    push_pkt(1, 2, 2, 210, 1'b0, 1'b1);
    fork
      send_pkt(0, 2, 2, 200);
      send_pkt(1, 2, 2, 210);
    join
    drain();
    chk("post_rst_grant", 64'(opGrant), 64'd1);
    chk("lerr_total", 64'(le_cnt), 64'd1);
    chk("to_total", 64'(to_cnt), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
